// File: rtl/accu_result_fifo_if.sv
// accu_result_fifo_if
// Handshake bundle between the accumulator, the result FIFO and its consumer.
// The producer side (in_*) is a bare strobe with no backpressure; the
// consumer side (out_*) is a valid/ready handshake.
// The slave modport is the FIFO's view; the master modport is the view of
// whatever drives the accumulator results and consumes the FIFO output.

interface accu_result_fifo_if #(
    parameter int DATA_W = 10
);

    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data,
        output in_valid,
        output out_ready,
        input  out_data,
        input  out_valid
    );

    modport slave (
        input  in_data,
        input  in_valid,
        input  out_ready,
        output out_data,
        output out_valid
    );

endinterface

// File: rtl/accu_result_fifo.sv
// accu_result_fifo
// Show-ahead FIFO behind the 8-sample accumulator. Results arrive as
// single-cycle strobes that cannot be stalled, so a result that finds the
// FIFO full (and not draining in the same cycle) is dropped. Each drop sets
// a sticky overflow flag and bumps a saturating 8-bit drop counter.
//
// Build option: define ACCU_AVG_EN to store in_data >> 3 (the floor mean of
// the 8 accumulated samples) instead of the raw sum. Ports are identical in
// both builds.
//
// DEPTH must be a power of two (>= 2) so the AW-bit pointers wrap on their
// own; occupancy is tracked separately in count.

module accu_result_fifo #(
    parameter int DATA_W = 10,
    parameter int DEPTH  = 4,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    accu_result_fifo_if.slave bus,
    output logic [AW:0]       count,
    output logic              full,
    output logic              empty,
    output logic              overflow,
    output logic [7:0]        drop_cnt
);

    localparam logic [AW:0] DEPTH_CNT = (AW + 1)'(DEPTH);
    localparam logic [7:0]  DROP_MAX  = 8'hFF;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr;
    logic              pop;
    logic              push;
    logic              drop;
    logic [DATA_W-1:0] store_word;

    // Status comes only from the registered count, so it moves on clock edges
    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // Show-ahead output: head word is visible whenever something is stored
    assign bus.out_valid = !empty;
    assign bus.out_data  = empty ? '0 : mem[rd_ptr];

    // A full FIFO can still accept a result if the head leaves this cycle
    assign pop  = bus.out_valid & bus.out_ready;
    assign push = bus.in_valid & (!full | pop);
    assign drop = bus.in_valid & full & !pop;

    // Select what gets written: raw accumulator sum or its floor mean
    always_comb begin
        store_word = bus.in_data;
`ifdef ACCU_AVG_EN
        store_word = bus.in_data >> 3;
`else
        store_word = bus.in_data;
`endif
    end

    // Storage array; contents are deliberately left unreset
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem[wr_ptr] <= store_word;
        end
    end

    // Pointers and occupancy; reset discards everything and blocks push/pop
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW + 1)'(1);
                2'b01:   count <= count - (AW + 1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Drop bookkeeping: sticky flag plus a counter that parks at 255
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != DROP_MAX) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_accu_result_fifo.sv
// tb_accu_result_fifo
// Directed bench for accu_result_fifo (DATA_W=10, DEPTH=4). Inputs change
// 1 ns after the rising edge and outputs are sampled there as well, well
// away from the active edge. Honours ACCU_AVG_EN for the stored-word model.

module tb_accu_result_fifo;

    localparam int DATA_W = 10;
    localparam int DEPTH  = 4;
    localparam int AW     = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          overflow;
    logic [7:0]    drop_cnt;

    int vectors     = 0;
    int miscompares = 0;

    accu_result_fifo_if #(.DATA_W(DATA_W)) bus ();

    accu_result_fifo #(
        .DATA_W(DATA_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .count   (count),
        .full    (full),
        .empty   (empty),
        .overflow(overflow),
        .drop_cnt(drop_cnt)
    );

    // Free-running 100 MHz clock
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] stored(input logic [DATA_W-1:0] v);
`ifdef ACCU_AVG_EN
        return v >> 3;
`else
        return v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        step();
        rst = 1'b0;
    endtask

    task automatic push_word(input logic [DATA_W-1:0] v);
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL reset_count got=%0d want=0", count); end
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_empty got=%0b want=1", empty); end
        vectors++; if (full !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_full got=%0b want=0", full); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_out_valid got=%0b want=0", bus.out_valid); end
        vectors++; if (bus.out_data !== 10'd0) begin miscompares++; $display("[TB] FAIL reset_out_data got=%0d want=0", bus.out_data); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_overflow got=%0b want=0", overflow); end
        vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL reset_drop_cnt got=%0d want=0", drop_cnt); end
    endtask

    task automatic test_basic();
        apply_reset();
        push_word(10'd100);
        push_word(10'd200);
        vectors++; if (count !== 3'd2) begin miscompares++; $display("[TB] FAIL basic_count got=%0d want=2", count); end
        vectors++; if (bus.out_data !== stored(10'd100)) begin miscompares++; $display("[TB] FAIL basic_head got=%0d want=%0d", bus.out_data, stored(10'd100)); end
        bus.out_ready = 1'b1;
        step();
        vectors++; if (bus.out_data !== stored(10'd200)) begin miscompares++; $display("[TB] FAIL basic_second got=%0d want=%0d", bus.out_data, stored(10'd200)); end
        vectors++; if (count !== 3'd1) begin miscompares++; $display("[TB] FAIL basic_count1 got=%0d want=1", count); end
        step();
        bus.out_ready = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_empty got=%0b want=1", empty); end
        vectors++; if (bus.out_data !== 10'd0) begin miscompares++; $display("[TB] FAIL basic_zero got=%0d want=0", bus.out_data); end
    endtask

    task automatic test_empty_push_ready();
        apply_reset();
        bus.out_ready = 1'b1;
        push_word(10'd55);
        vectors++; if (count !== 3'd1) begin miscompares++; $display("[TB] FAIL empty_pr_count got=%0d want=1", count); end
        vectors++; if (bus.out_data !== stored(10'd55)) begin miscompares++; $display("[TB] FAIL empty_pr_data got=%0d want=%0d", bus.out_data, stored(10'd55)); end
        step();
        bus.out_ready = 1'b0;
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL empty_pr_drained got=%0b want=0", bus.out_valid); end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 1; i <= 4; i++) push_word(DATA_W'(i));
        vectors++; if (full !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_full got=%0b want=1", full); end
        push_word(10'd5);
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_flag got=%0b want=1", overflow); end
        vectors++; if (drop_cnt !== 8'd1) begin miscompares++; $display("[TB] FAIL ovf_drop_cnt got=%0d want=1", drop_cnt); end
        vectors++; if (count !== 3'd4) begin miscompares++; $display("[TB] FAIL ovf_count got=%0d want=4", count); end
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            vectors++; if (bus.out_data !== stored(DATA_W'(i))) begin miscompares++; $display("[TB] FAIL ovf_drain_%0d got=%0d want=%0d", i, bus.out_data, stored(DATA_W'(i))); end
            step();
        end
        bus.out_ready = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_empty got=%0b want=1", empty); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL ovf_sticky got=%0b want=1", overflow); end
    endtask

    task automatic test_full_push_pop();
        logic [DATA_W-1:0] exp_seq [4];
        exp_seq[0] = 10'd2; exp_seq[1] = 10'd3; exp_seq[2] = 10'd4; exp_seq[3] = 10'd9;
        apply_reset();
        for (int i = 1; i <= 4; i++) push_word(DATA_W'(i));
        bus.out_ready = 1'b1;
        push_word(10'd9);
        vectors++; if (count !== 3'd4) begin miscompares++; $display("[TB] FAIL fpp_count got=%0d want=4", count); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL fpp_overflow got=%0b want=0", overflow); end
        vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL fpp_drop_cnt got=%0d want=0", drop_cnt); end
        for (int i = 0; i < 4; i++) begin
            vectors++; if (bus.out_data !== stored(exp_seq[i])) begin miscompares++; $display("[TB] FAIL fpp_drain_%0d got=%0d want=%0d", i, bus.out_data, stored(exp_seq[i])); end
            step();
        end
        bus.out_ready = 1'b0;
        vectors++; if (empty !== 1'b1) begin miscompares++; $display("[TB] FAIL fpp_empty got=%0b want=1", empty); end
    endtask

    task automatic test_interleave();
        int next_in  = 0;
        int next_out = 0;
        int occ      = 0;
        int cyc      = 0;
        apply_reset();
        while (next_out < 10 && cyc < 400) begin
            bus.in_valid  = (next_in < 10) && (occ < DEPTH) && ($urandom_range(1, 0) == 1);
            bus.in_data   = DATA_W'(next_in);
            bus.out_ready = 1'($urandom_range(1, 0));
            if (occ > 0 && bus.out_ready) begin
                vectors++; if (bus.out_data !== stored(DATA_W'(next_out))) begin miscompares++; $display("[TB] FAIL ilv_pop_%0d got=%0d want=%0d", next_out, bus.out_data, stored(DATA_W'(next_out))); end
                next_out++;
                occ--;
            end
            if (bus.in_valid) begin
                next_in++;
                occ++;
            end
            step();
            cyc++;
            vectors++; if (count !== 3'(occ)) begin miscompares++; $display("[TB] FAIL ilv_count_c%0d got=%0d want=%0d", cyc, count, occ); end
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        vectors++; if (next_out != 10) begin miscompares++; $display("[TB] FAIL ilv_timeout got=%0d want=10 words", next_out); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        for (int i = 1; i <= 4; i++) push_word(DATA_W'(i));
        push_word(10'd5);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        vectors++; if (count !== 3'd3) begin miscompares++; $display("[TB] FAIL rmid_pre_count got=%0d want=3", count); end
        vectors++; if (overflow !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_pre_ovf got=%0b want=1", overflow); end
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 10'd77;
        bus.out_ready = 1'b1;
        step();
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        vectors++; if (count !== 3'd0) begin miscompares++; $display("[TB] FAIL rmid_count got=%0d want=0", count); end
        vectors++; if (bus.out_valid !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_out_valid got=%0b want=0", bus.out_valid); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_overflow got=%0b want=0", overflow); end
        vectors++; if (drop_cnt !== 8'd0) begin miscompares++; $display("[TB] FAIL rmid_drop_cnt got=%0d want=0", drop_cnt); end
        push_word(10'd42);
        vectors++; if (bus.out_data !== stored(10'd42)) begin miscompares++; $display("[TB] FAIL rmid_push got=%0d want=%0d", bus.out_data, stored(10'd42)); end
        vectors++; if (count !== 3'd1) begin miscompares++; $display("[TB] FAIL rmid_push_count got=%0d want=1", count); end
    endtask

    task automatic test_drop_saturate();
        apply_reset();
        for (int i = 11; i <= 14; i++) push_word(DATA_W'(i));
        bus.in_valid  = 1'b1;
        bus.in_data   = 10'd500;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (i == 99) begin
                vectors++; if (drop_cnt !== 8'd100) begin miscompares++; $display("[TB] FAIL sat_mid got=%0d want=100", drop_cnt); end
            end
            if (i == 254) begin
                vectors++; if (drop_cnt !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_reach got=%0d want=255", drop_cnt); end
            end
        end
        bus.in_valid = 1'b0;
        vectors++; if (drop_cnt !== 8'd255) begin miscompares++; $display("[TB] FAIL sat_hold got=%0d want=255", drop_cnt); end
        vectors++; if (count !== 3'd4) begin miscompares++; $display("[TB] FAIL sat_count got=%0d want=4", count); end
        bus.out_ready = 1'b1;
        for (int i = 11; i <= 14; i++) begin
            vectors++; if (bus.out_data !== stored(DATA_W'(i))) begin miscompares++; $display("[TB] FAIL sat_drain_%0d got=%0d want=%0d", i, bus.out_data, stored(DATA_W'(i))); end
            step();
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_avg();
        logic [DATA_W-1:0] want_big;
        logic [DATA_W-1:0] want_small;
`ifdef ACCU_AVG_EN
        want_big   = 10'd127;
        want_small = 10'd0;
`else
        want_big   = 10'd1020;
        want_small = 10'd7;
`endif
        apply_reset();
        push_word(10'd1020);
        vectors++; if (bus.out_data !== want_big) begin miscompares++; $display("[TB] FAIL avg_1020 got=%0d want=%0d", bus.out_data, want_big); end
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        push_word(10'd7);
        vectors++; if (bus.out_data !== want_small) begin miscompares++; $display("[TB] FAIL avg_7 got=%0d want=%0d", bus.out_data, want_small); end
        vectors++; if (bus.out_valid !== 1'b1) begin miscompares++; $display("[TB] FAIL avg_valid got=%0b want=1", bus.out_valid); end
    endtask

    // Run every scenario in order, then report
    initial begin
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_empty_push_ready();
        test_overflow();
        test_full_push_pop();
        test_interleave();
        test_reset_mid();
        test_drop_saturate();
        test_avg();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/accu_result_fifo.md
Name: accu_result_fifo

Overview:
- Downstream stage of the 8-sample accumulator.
- Captures each accumulated result, which arrives as a single-cycle valid pulse with no backpressure.
- Buffers results in a small show-ahead FIFO and presents them to the consumer over a valid/ready handshake.
- Because the accumulator cannot be stalled, any result arriving while the FIFO is full is dropped, flagged and counted.

Parameters:
- DATA_W, 10, width of the result word; matches the accumulator output.
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, $clog2(DEPTH), pointer width; derived, not overridden.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_data  input  DATA_W  result word from the accumulator.
- in_valid  input  1  single-cycle strobe qualifying in_data.
- out_data  output  DATA_W  head-of-FIFO word; 0 whenever out_valid=0.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- count  output  AW+1  current occupancy, 0..DEPTH.
- full  output  1  count==DEPTH.
- empty  output  1  count==0.
- overflow  output  1  sticky flag: a result was dropped.
- drop_cnt  output  8  number of dropped results, saturating at 255.

Behaviour:
- Reset (synchronous, rst=1 at a rising edge):
  - rd_ptr=0, wr_ptr=0, count=0.
  - out_valid=0, out_data=0, full=0, empty=1.
  - overflow=0, drop_cnt=0.
  - Memory contents are not reset.
- rst has priority over every other input.
- Reset asserted mid-operation discards all stored entries. In that same cycle no push, pop or drop is recorded.
- pop = out_valid & out_ready.
- push = in_valid & (!full | pop).
- drop = in_valid & full & !pop.
- Push: write mem[wr_ptr] and increment wr_ptr modulo DEPTH.
- Pop: increment rd_ptr modulo DEPTH.
- Pointers wrap naturally; AW-bit pointers, with occupancy tracked by count.
- count next value:
  - push & !pop: count+1.
  - pop & !push: count-1.
  - both or neither: unchanged.
- Latency: a word pushed at edge N is visible as out_valid=1 / out_data after edge N.
- Empty FIFO with in_valid=1 and out_ready=1: push only. No pop, since out_valid was 0. The word appears next cycle.
- Full FIFO with in_valid=1 and out_ready=1: pop and push both occur. count stays at DEPTH and no drop is recorded.
- Full FIFO with in_valid=1 and out_ready=0:
  - Word is discarded; contents unchanged.
  - overflow set to 1 and held until reset.
  - drop_cnt increments, holding at 255 once reached.
- out_ready while empty has no effect.
- Consumer may hold out_ready high continuously.
- out_data = mem[rd_ptr] when !empty, else 0. It is combinational from the registered pointer and memory; no bubble between back-to-back pops.
- full, empty and out_valid are derived from the registered count and change only on clock edges.
- FIFO order is strictly preserved across pointer wrap.

Optional Feature:
- Macro: ACCU_AVG_EN.
- Defined:
  - The stored word is in_data >> 3, zero-extended to DATA_W. This is the floor mean of the 8 accumulated samples.
  - Drop/overflow logic is unchanged.
- Undefined: in_data is stored unmodified.
- Port list and widths are identical in both builds.

Test Plan:
- Push 100 then 200 with out_ready=0 -> count=2, out_data=100. Then out_ready=1 for 2 cycles -> 100, then 200 accepted, then empty=1, out_data=0.
- Fill DEPTH=4 with 1,2,3,4, then push 5 with out_ready=0 -> overflow=1, drop_cnt=1, count=4. Drain yields 1,2,3,4 exactly.
- FIFO full (1..4), push 9 with out_ready=1 -> 1 popped, 9 accepted, count=4, overflow=0. Drain yields 2,3,4,9.
- Interleave 10 pushes (values 0..9) with random out_ready, never overflowing -> output sequence 0..9 in order, pointers wrapped twice.
- count=3 and overflow=1, then rst=1 for one cycle -> next cycle count=0, out_valid=0, overflow=0, drop_cnt=0. A push the following cycle appears one cycle later.
- 300 drops while full -> drop_cnt=255 and held. With ACCU_AVG_EN: push 1020 -> out_data=127; push 7 -> out_data=0.
